// File: rtl/aes_subbytes_serial_if.sv
// Byte-stream handshake bundle (valid/ready/data) used on both sides of the
// SubBytes/ShiftRows stage. The producer uses the master modport and the consumer uses the slave modport.
interface aes_subbytes_serial_if;
  logic       valid;
  logic       ready;
  logic [7:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/aes_subbytes_serial.sv
// Byte-serial AES SubBytes + ShiftRows stage.
// Loads a 16-byte state block one byte at a time through an external
// combinational S-box, then emits the substituted bytes in ShiftRows order
// (or identity order when SHIFT_ROWS = 0).
// Optional macro AES_SBOX_PIPE_EN registers the S-box input. This adds a
// one-cycle FLUSH state so that the last substituted byte lands in the buffer
// before the drain starts.
module aes_subbytes_serial #(
  parameter int SHIFT_ROWS = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  aes_subbytes_serial_if.slave          in_if,
  aes_subbytes_serial_if.master         out_if,
  output logic [7:0]                    sbox_a,
  input  logic [7:0]                    sbox_q,
  output logic                          busy
);

  typedef enum logic [1:0] {LOAD = 2'd0, FLUSH = 2'd1, DRAIN = 2'd2} state_t;

  state_t     state_q, state_d;
  logic [3:0] wr_idx_q, wr_idx_d;
  logic [3:0] rd_idx_q, rd_idx_d;
  logic [7:0] buf_q [16];

  logic       in_ready;
  logic       out_valid;
  logic       accept;
  logic       xfer;
  logic [3:0] src_idx;
  logic       wr_en;
  logic [3:0] wr_ptr;

  assign accept = in_if.valid & in_ready;
  assign xfer   = out_valid & out_if.ready;

  // Column k of the output row r comes from column (k + r) of the input, which maps to this index.
  assign src_idx = (SHIFT_ROWS != 0) ? (rd_idx_q + {rd_idx_q[1:0], 2'b00}) : rd_idx_q;

  // State register and buffer indices. Reset discards any partial block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= LOAD;
      wr_idx_q <= 4'd0;
      rd_idx_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
    end
  end

  // Next-state logic: fill 16 bytes, optionally flush the pipeline, then drain 16 bytes.
  always_comb begin
    state_d  = state_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    case (state_q)
      LOAD: begin
        if (accept) begin
          wr_idx_d = wr_idx_q + 4'd1;
          if (wr_idx_q == 4'd15) begin
`ifdef AES_SBOX_PIPE_EN
            state_d = FLUSH;
`else
            state_d = DRAIN;
`endif
          end
        end
      end
`ifdef AES_SBOX_PIPE_EN
      FLUSH: state_d = DRAIN;
`endif
      DRAIN: begin
        if (xfer) begin
          rd_idx_d = rd_idx_q + 4'd1;
          if (rd_idx_q == 4'd15) state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Output decode. Gating with rst_n keeps the handshake quiet while reset is held.
  always_comb begin
    in_ready    = rst_n && (state_q == LOAD);
    out_valid   = rst_n && (state_q == DRAIN);
    busy        = rst_n && ((state_q != LOAD) || (wr_idx_q != 4'd0));
    in_if.ready = in_ready;
    out_if.valid = out_valid;
    out_if.data  = out_valid ? buf_q[src_idx] : 8'h00;
  end

`ifdef AES_SBOX_PIPE_EN
  logic [7:0] sbox_a_q, sbox_a_d;
  logic       wr_en_q, wr_en_d;
  logic [3:0] wr_ptr_q, wr_ptr_d;

  // S-box input register plus the write enable and write index, delayed to match.
  always_comb begin
    sbox_a_d = accept ? in_if.data : 8'h00;
    wr_en_d  = accept;
    wr_ptr_d = wr_idx_q;
  end

  // Pipeline stage that breaks the upstream -> S-box -> buffer path.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sbox_a_q <= 8'h00;
      wr_en_q  <= 1'b0;
      wr_ptr_q <= 4'd0;
    end else begin
      sbox_a_q <= sbox_a_d;
      wr_en_q  <= wr_en_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  assign sbox_a = sbox_a_q;
  assign wr_en  = wr_en_q;
  assign wr_ptr = wr_ptr_q;
`else
  assign sbox_a = accept ? in_if.data : 8'h00;
  assign wr_en  = accept;
  assign wr_ptr = wr_idx_q;
`endif

  // Substituted-byte buffer. It has no reset because out_data is gated while the buffer is not being drained.
  always_ff @(posedge clk) begin
    if (wr_en) buf_q[wr_ptr] <= sbox_q;
  end

endmodule

// File: tb/tb_aes_subbytes_serial.sv
// Scoreboard bench for aes_subbytes_serial: a ShiftRows instance and an
// identity-order instance share the stimulus; each has its own expected queue.
module tb_aes_subbytes_serial;

`ifdef AES_SBOX_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;
  int         or_mode;
  int         cyc = 0;

  logic [7:0] sa0, sa1, sq0, sq1;
  logic       busy0, busy1;

  int total = 0;
  int bad   = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];

  logic [7:0] fips_in [16] = '{8'h19, 8'h3d, 8'he3, 8'hbe, 8'ha0, 8'hf4, 8'he2, 8'h2b,
                               8'h9a, 8'hc6, 8'h8d, 8'h2a, 8'he9, 8'hf8, 8'h48, 8'h08};
  logic [7:0] fips_sr [16] = '{8'hd4, 8'hbf, 8'h5d, 8'h30, 8'he0, 8'hb4, 8'h52, 8'hae,
                               8'hb8, 8'h41, 8'h11, 8'hf1, 8'h1e, 8'h27, 8'h98, 8'he5};
  logic [7:0] fips_id [16] = '{8'hd4, 8'h27, 8'h11, 8'hae, 8'he0, 8'hbf, 8'h98, 8'hf1,
                               8'hb8, 8'hb4, 8'h5d, 8'he5, 8'h1e, 8'h41, 8'h52, 8'h30};

  aes_subbytes_serial_if in0 ();
  aes_subbytes_serial_if out0 ();
  aes_subbytes_serial_if in1 ();
  aes_subbytes_serial_if out1 ();

  assign in0.valid  = in_valid;
  assign in0.data   = in_data;
  assign out0.ready = out_ready;
  assign in1.valid  = in_valid;
  assign in1.data   = in_data;
  assign out1.ready = out_ready;

  aes_subbytes_serial #(.SHIFT_ROWS(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_if(in0), .out_if(out0),
    .sbox_a(sa0), .sbox_q(sq0), .busy(busy0));
  aes_subbytes_serial #(.SHIFT_ROWS(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_if(in1), .out_if(out1),
    .sbox_a(sa1), .sbox_q(sq1), .busy(busy1));

  // Stand-in for the external combinational S-box: GF(2^8) inverse followed by the affine map
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_f(input logic [7:0] x);
    logic [7:0] inv, s;
    inv = 8'h00;
    for (int i = 1; i < 256; i++)
      if (x != 8'h00 && gmul(x, 8'(i)) == 8'h01) inv = 8'(i);
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  assign sq0 = sbox_f(sa0);
  assign sq1 = sbox_f(sa1);

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    out_ready = (or_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor state
  int   acc_cnt = 0, out_cnt = 0, last_acc = 0;
  logic prev_ov = 1'b0, prev_stall = 1'b0, want_ready = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("in_ready_in_reset", 32'(in0.ready), 32'd0);
      acc_cnt = 0; out_cnt = 0;
      prev_ov = 1'b0; prev_stall = 1'b0; want_ready = 1'b0;
    end else begin
      if (want_ready) begin
        chk("in_ready_after_drain", 32'(in0.ready), 32'd1);
        want_ready = 1'b0;
      end
      if (in_valid && in0.ready) begin
        if (acc_cnt == 15) last_acc = cyc;
        acc_cnt = (acc_cnt + 1) % 16;
      end
      if (out0.valid && !prev_ov) chk("first_out_latency", 32'(cyc - last_acc), 32'(LAT));
      if (out0.valid) chk("no_in_ready_in_drain", 32'(in0.ready), 32'd0);
      if (prev_stall && out0.valid) chk("stall_hold", 32'(out0.data), 32'(prev_data));
      if (!out0.valid) chk("out_data_gated", 32'(out0.data), 32'd0);
      // ShiftRows instance
      if (out0.valid && out_ready) begin
        if (q0.size() == 0) begin
          total++; bad++;
          $display("FAIL spurious_out_sr: got=%h expected=none", out0.data);
        end else chk("out_sr", 32'(out0.data), 32'(q0.pop_front()));
        out_cnt++;
        if (out_cnt == 16) begin out_cnt = 0; want_ready = 1'b1; end
      end
      // Identity-order instance
      if (out1.valid && out_ready) begin
        if (q1.size() == 0) begin
          total++; bad++;
          $display("FAIL spurious_out_id: got=%h expected=none", out1.data);
        end else chk("out_id", 32'(out1.data), 32'(q1.pop_front()));
      end
      prev_stall = out0.valid && !out_ready;
      prev_data  = out0.data;
      prev_ov    = out0.valid;
    end
  end

  task automatic send_byte(input logic [7:0] d, input int gap);
    logic ok;
    int   tries;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = d;
    tries = 0;
    ok = 1'b0;
    while (!ok && tries < 300) begin
      @(negedge clk);
      ok = in0.ready;
      @(posedge clk); #1;
      tries++;
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL accept_timeout: byte=%h not accepted in %0d cycles", d, tries);
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 600) begin
      @(posedge clk); n++;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: pending sr=%0d id=%0d", q0.size(), q1.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic push_fips();
    for (int i = 0; i < 16; i++) begin
      q0.push_back(fips_sr[i]);
      q1.push_back(fips_id[i]);
    end
  endtask

  task automatic push_zeros();
    for (int i = 0; i < 16; i++) begin
      q0.push_back(8'h63);
      q1.push_back(8'h63);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; or_mode = 0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 32'(out0.valid), 32'd0);
    chk("rst_out_data", 32'(out0.data), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_sbox_a", 32'(sa0), 32'd0);
    chk("rst_in_ready", 32'(in0.ready), 32'd1);
    @(posedge clk); #1;

    // FIPS-197 round-1 state, continuous flow
    $display("block: fips state, out_ready=1");
    push_fips();
    for (int i = 0; i < 16; i++) begin
      send_byte(fips_in[i], 0);
      if (i == 0) begin
        @(negedge clk);
        chk("busy_mid_load", 32'(busy0), 32'd1);
        @(posedge clk); #1;
      end
    end
    wait_drain();

    // All-zero block with random input gaps
    $display("block: zeros with in_valid gaps");
    push_zeros();
    for (int i = 0; i < 16; i++) send_byte(8'h00, $urandom_range(0, 3));
    wait_drain();

    // Output backpressure
    $display("block: fips state with out_ready stalls");
    or_mode = 1;
    push_fips();
    for (int i = 0; i < 16; i++) send_byte(fips_in[i], 0);
    wait_drain();
    or_mode = 0;
    repeat (2) begin @(posedge clk); #1; end

    // Reset after 7 accepted bytes, then a full block
    $display("block: 7 bytes then reset, then fips state");
    for (int i = 0; i < 7; i++) send_byte(8'hff - 8'(i), 0);
    rst_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy0), 32'd0);
    chk("post_rst_out_valid", 32'(out0.valid), 32'd0);
    @(posedge clk); #1;
    push_fips();
    for (int i = 0; i < 16; i++) send_byte(fips_in[i], 0);
    wait_drain();

    // Back-to-back blocks
    $display("block: zeros then fips back-to-back");
    push_zeros();
    push_fips();
    for (int i = 0; i < 16; i++) send_byte(8'h00, 0);
    for (int i = 0; i < 16; i++) send_byte(fips_in[i], 0);
    wait_drain();

    chk("sr_queue_empty", 32'(q0.size()), 32'd0);
    chk("id_queue_empty", 32'(q1.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_subbytes_serial.md
# aes_subbytes_serial

Byte-serial SubBytes + ShiftRows stage of the 8-bit AES-128 datapath, placed directly upstream of the round's MixColumns/AddRoundKey byte stage. It accepts one 16-byte state block one byte at a time and drives each byte through an external combinational Canright S-box instance (`bSbox`). It buffers the substituted bytes and emits them in ShiftRows order over a valid/ready handshake.

## Interface
- `SHIFT_ROWS`, default 1: 1 = emit bytes in ShiftRows order; 0 = emit in input (identity) order.

- `clk` in 1: sole clock; all state changes on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `in_valid` in 1: `in_data` carries a state byte.
- `in_ready` out 1: stage accepts a byte this cycle.
- `in_data` in 8: state byte, column-major order (index i = row + 4·col).
- `sbox_a` out 8: byte to the external `bSbox` A input.
- `sbox_q` in 8: substituted byte from the external `bSbox` Q output (combinational).
- `out_valid` out 1: `out_data` holds an output byte.
- `out_ready` in 1: downstream accepts the byte.
- `out_data` out 8: substituted byte; forced to 8'h00 when `out_valid`=0.
- `busy` out 1: high in any state other than LOAD, or in LOAD with `wr_idx` ≠ 0.

## Operation
- Storage: 16×8 buffer `buf`, 4-bit write index `wr_idx`, 4-bit read index `rd_idx`.
- States:
  - **LOAD**:
    - `in_ready`=1.
    - Each accepted byte (`in_valid & in_ready`) is substituted and written to `buf[wr_idx]`; `wr_idx` increments.
    - On the 16th accept (`wr_idx`=15), go to FLUSH (macro defined) or DRAIN (macro undefined). `wr_idx` wraps to 0.
  - **FLUSH** (only with macro): one cycle.
    - `in_ready`=0; the last pipelined byte is written.
    - Go to DRAIN.
  - **DRAIN**:
    - `in_ready`=0, `out_valid`=1.
    - `out_data` = `buf[src(rd_idx)]`.
    - Each `out_valid & out_ready` increments `rd_idx`.
    - On the 16th transfer, `rd_idx` wraps to 0 and the state returns to LOAD.
- Source mapping: with `SHIFT_ROWS`=1, src(k) = (k + 4·(k mod 4)) mod 16, all 4-bit arithmetic. With `SHIFT_ROWS`=0, src(k) = k.
- No overlap: a new block is not accepted until the previous block has fully drained.
- `in_valid` may drop between bytes; `wr_idx` holds.
- `out_ready` low holds `rd_idx` and `out_data` stable.
- Reset while `rst_n`=0 at any edge, including mid-LOAD or mid-DRAIN:
  - state → LOAD, `wr_idx`=`rd_idx`=0.
  - Partially loaded bytes are discarded.
  - `buf` contents are not cleared; they are unobservable because `out_data` is gated.

## Timing
- Reset values: `out_valid`=0, `out_data`=8'h00, `busy`=0, `sbox_a`=8'h00.
- `in_ready` is 0 while `rst_n` is low and 1 in the first cycle after release.
- Without macro:
  - `sbox_a` = `in_data` combinationally when `in_valid & in_ready`, else 8'h00.
  - `sbox_q` is written to `buf` at the same edge.
  - `out_valid` rises the cycle after the 16th input accept.
- With macro:
  - See Configuration for the `sbox_a` register.
  - `out_valid` rises 2 cycles after the 16th accept.
- Throughput: one byte per cycle in and out. Minimum block period is 32 cycles (33 with macro).

## Configuration
- `AES_SBOX_PIPE_EN` defined:
  - `sbox_a` is registered; it loads `in_data` on accept and is cleared to 8'h00 otherwise.
  - A registered write-enable and write index follow the accept by one cycle.
  - `sbox_q` is written one cycle after accept.
  - The FLUSH state exists.
  - This breaks the upstream→S-box→buffer combinational path.
- Undefined: the direct combinational path is used and there is no FLUSH state.
- Behaviour of the byte stream is identical in both cases; only latency differs.

## Test plan
- FIPS-197 round-1 state 19 3d e3 be a0 f4 e2 2b 9a c6 8d 2a e9 f8 48 08, `out_ready`=1 → outputs d4 bf 5d 30 e0 b4 52 ae b8 41 11 f1 1e 27 98 e5. The first `out_valid` appears 1 cycle (2 with macro) after the last accept.
- Same input with `SHIFT_ROWS`=0 → d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30.
- 16 bytes of 00 with random `in_valid` gaps → 16 bytes of 63. `in_ready` is never high during DRAIN.
- Backpressure: `out_ready` toggling 1,0,0,1,… during DRAIN → `out_data` stable while stalled, no byte skipped or duplicated, exactly 16 transfers.
- Reset asserted after 7 accepted bytes, then the FIPS state is sent → output equals the first scenario, with no residue from the 7 discarded bytes.
- Two back-to-back blocks (zeros, then the FIPS state) → 16×63 followed by the ShiftRows vector. `in_ready` returns to 1 the cycle after the 16th output transfer.
